player_bullet: RTL

- Upstream stage of the invaders block: generates the player's single bullet and drives the invaders block's i_bullet_x / i_bullet_y.
- Consumes its registered o_hit.
- Launches on a fire-button press from the player's current column, then climbs one row per move tick from the bottom of the 20x16 playfield to the top.
- Retires the bullet on hit or on leaving the top; keeps a hit score.

---
 rtl/player_bullet.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/player_bullet.sv
// Player bullet for the invaders playfield: fire-edge launch, one-row climb per
// move tick, retire on hit or top exit, saturating hit score.
module timer_1us #(
    parameter int SPEED = 20000
) (
    input  logic i_clk_25MHz,
    input  logic i_reset,
    output logic o_tick
);
    localparam int SW = $clog2(SPEED + 1);

    logic [4:0]    us_cnt;
    logic [SW-1:0] sp_cnt;
    logic          us_end;
    logic          sp_end;

    assign us_end = (us_cnt == 5'd24);
    assign sp_end = (sp_cnt == SW'(SPEED - 1));

    // 25 clocks make one microsecond; SPEED microseconds make one tick
    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            us_cnt <= '0;
            sp_cnt <= '0;
            o_tick <= 1'b0;
        end else begin
            o_tick <= us_end && sp_end;
            if (us_end) begin
                us_cnt <= '0;
                sp_cnt <= sp_end ? '0 : sp_cnt + 1'b1;
            end else begin
                us_cnt <= us_cnt + 1'b1;
            end
        end
    end
endmodule

module player_bullet #(
    parameter int         SPEED   = 20000,
    parameter logic [3:0] START_Y = 4'd14,
    parameter logic [4:0] MAX_X   = 5'd19
) (
    input  logic       i_clk_25MHz,
    input  logic       i_reset,
    input  logic       i_fire,
    input  logic [4:0] i_player_x,
    input  logic       i_hit,
    output logic [4:0] o_bullet_x,
    output logic [3:0] o_bullet_y,
    output logic       o_active,
    output logic       o_miss,
    output logic [7:0] o_hit_count
);
    typedef enum logic [1:0] {
        IDLE,
        FLYING,
        HITWAIT
    } state_t;

    state_t     state, state_n;
    logic       fire_q;
    logic       press;
    logic       tick;
    logic [4:0] x_n;
    logic [3:0] y_n;
    logic       active_n;
    logic       miss_n;
    logic [7:0] count_n;

    timer_1us #(.SPEED(SPEED)) u_timer (
        .i_clk_25MHz(i_clk_25MHz),
        .i_reset    (i_reset),
        .o_tick     (tick)
    );

    assign press = i_fire & ~fire_q;

    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            state       <= IDLE;
            fire_q      <= 1'b1;
            o_bullet_x  <= '0;
            o_bullet_y  <= '0;
            o_active    <= 1'b0;
            o_miss      <= 1'b0;
            o_hit_count <= '0;
        end else begin
            state       <= state_n;
            fire_q      <= i_fire;
            o_bullet_x  <= x_n;
            o_bullet_y  <= y_n;
            o_active    <= active_n;
            o_miss      <= miss_n;
            o_hit_count <= count_n;
        end
    end

    always_comb begin
        state_n  = state;
        x_n      = o_bullet_x;
        y_n      = o_bullet_y;
        active_n = o_active;
        miss_n   = 1'b0;
        count_n  = o_hit_count;
        unique case (state)
            IDLE: begin
                if (press && (i_player_x <= MAX_X)) begin
                    x_n      = i_player_x;
                    y_n      = START_Y;
                    active_n = 1'b1;
                    state_n  = FLYING;
                end
            end
            FLYING: begin
                // a hit outranks a tick, so a same-cycle top exit is never a miss
                if (i_hit) begin
                    if (o_hit_count != 8'hFF)
                        count_n = o_hit_count + 1'b1;
                    y_n      = '0;
                    active_n = 1'b0;
                    state_n  = HITWAIT;
                end else if (tick && (o_bullet_y == 4'd1)) begin
                    y_n      = '0;
                    active_n = 1'b0;
                    miss_n   = 1'b1;
                    state_n  = IDLE;
                end else if (tick) begin
                    y_n = o_bullet_y - 4'd1;
                end
            end
            HITWAIT: begin
                if (!i_hit)
                    state_n = IDLE;
            end
            default: begin
                state_n  = IDLE;
                y_n      = '0;
                active_n = 1'b0;
            end
        endcase
    end
endmodule
